// File: rtl/op_sequencer_if.sv
// Handshake bundle between instruction fetch, the sequencer and the execute stage.
// The slave modport is the sequencer's view; master is the fetch/execute side.
interface op_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned RS_W   = 2,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dec_valid;
  logic              dec_ready;
  logic [OP_W-2:0]   op_sel;
  logic [RS_W-1:0]   reg_sel_d;
  logic [RS_W-1:0]   reg_sel_s;
  logic              imm_en;
  logic [DATA_W-1:0] imm;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  modport slave (
    input  in_valid, in_data, dec_ready,
    output in_ready, dec_valid, op_sel, reg_sel_d, reg_sel_s, imm_en, imm, halted, instr_count
  );

  modport master (
    output in_valid, in_data, dec_ready,
    input  in_ready, dec_valid, op_sel, reg_sel_d, reg_sel_s, imm_en, imm, halted, instr_count
  );
endinterface

// File: rtl/op_sequencer.sv
// Multi-cycle instruction sequencer: splits instruction words, fetches an immediate for
// immediate-class opcodes, issues one decoded instruction at a time and latches HALT.
module op_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned RS_W   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StFetch, StImm, StIssue, StHalt} state_e;

  state_e            state_q;
  logic [OP_W-2:0]   op_sel_q;
  logic [RS_W-1:0]   rd_q;
  logic [RS_W-1:0]   rs_q;
  logic              imm_en_q;
  logic [DATA_W-1:0] imm_q;
  logic              halted_q;
  logic [CNT_W-1:0]  count_q;

  logic [OP_W-1:0]   opcode;
  logic [RS_W-1:0]   in_rd;
  logic [RS_W-1:0]   in_rs;

  assign opcode = bus.in_data[DATA_W-1 -: OP_W];
  assign in_rd  = bus.in_data[2*RS_W-1 -: RS_W];
  assign in_rs  = bus.in_data[RS_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      op_sel_q <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus.in_valid) begin
            op_sel_q <= opcode[OP_W-2:0];
            rd_q     <= in_rd;
            rs_q     <= in_rs;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            if (&opcode) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else if (opcode[OP_W-1]) begin
              state_q <= StImm;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        // The whole word is the immediate; its field split is irrelevant here.
        StImm: begin
          if (bus.in_valid) begin
            imm_q    <= bus.in_data;
            imm_en_q <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (bus.dec_ready) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= StFetch;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  // Handshake outputs depend on state alone, so no valid->ready combinational path exists.
  assign bus.in_ready    = (state_q == StFetch) || (state_q == StImm);
  assign bus.dec_valid   = (state_q == StIssue);
  assign bus.op_sel      = op_sel_q;
  assign bus.reg_sel_d   = rd_q;
  assign bus.reg_sel_s   = rs_q;
  assign bus.imm_en      = imm_en_q;
  assign bus.imm         = imm_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: a scoreboard queue holds the expected decode of each
// instruction driven in, and is popped when the sequencer issues it.
module tb_op_sequencer;

  typedef struct packed {
    logic [2:0] op_sel;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       imm_en;
    logic [7:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_count = 0;
  exp_t sb[$];

  op_sequencer_if #(.DATA_W(8), .OP_W(4), .RS_W(2), .CNT_W(16)) bus ();

  op_sequencer #(.DATA_W(8), .OP_W(4), .RS_W(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                               input logic ie, input logic [7:0] im);
    exp_t e;
    e.op_sel = op;
    e.rd     = rd;
    e.rs     = rs;
    e.imm_en = ie;
    e.imm    = im;
    sb.push_back(e);
  endfunction

  // Present one word and hold it until an accepting edge passes (bounded).
  task automatic send(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    check("send_accept", {31'd0, ok}, 32'd1);
  endtask

  // Wait for dec_valid, compare against the scoreboard head, then complete the handshake.
  task automatic issue();
    logic ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.dec_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("issue_wait", {31'd0, ok}, 32'd1);
    check("sb_pending", {31'd0, sb.size() > 0}, 32'd1);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      check("op_sel", 32'(bus.op_sel), 32'(e.op_sel));
      check("reg_sel_d", 32'(bus.reg_sel_d), 32'(e.rd));
      check("reg_sel_s", 32'(bus.reg_sel_s), 32'(e.rs));
      check("imm_en", 32'(bus.imm_en), 32'(e.imm_en));
      check("imm", 32'(bus.imm), 32'(e.imm));
      bus.dec_ready = 1'b1;
      tick();
      bus.dec_ready = 1'b0;
      exp_count++;
      check("post_issue_dec_valid", 32'(bus.dec_valid), 32'd0);
      check("post_issue_in_ready", 32'(bus.in_ready), 32'd1);
      check("instr_count", 32'(bus.instr_count), 32'(exp_count));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    sb.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'd0);
    check({tag, "_op_sel"}, 32'(bus.op_sel), 32'd0);
    check({tag, "_rd"}, 32'(bus.reg_sel_d), 32'd0);
    check({tag, "_rs"}, 32'(bus.reg_sel_s), 32'd0);
    check({tag, "_imm_en"}, 32'(bus.imm_en), 32'd0);
    check({tag, "_imm"}, 32'(bus.imm), 32'd0);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
    check({tag, "_count"}, 32'(bus.instr_count), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.dec_ready = 1'b0;
    tick();
    do_reset();
    check_idle("reset");

    // Register op: dec_valid must be up in the cycle right after acceptance.
    push(3'd2, 2'd3, 2'd1, 1'b0, 8'h00);
    send(8'h2D);
    check("reg_dec_valid_n1", 32'(bus.dec_valid), 32'd1);
    check("reg_in_ready_issue", 32'(bus.in_ready), 32'd0);
    issue();

    // Immediate op with a 3-cycle gap before the immediate word.
    push(3'd1, 2'd1, 2'd0, 1'b1, 8'hA5);
    send(8'h94);
    for (int i = 0; i < 3; i++) begin
      check("gap_in_ready", 32'(bus.in_ready), 32'd1);
      check("gap_dec_valid", 32'(bus.dec_valid), 32'd0);
      tick();
    end
    send(8'hA5);
    check("imm_dec_valid_m1", 32'(bus.dec_valid), 32'd1);
    issue();

    // Backpressure: five stalled cycles with garbage on the input side.
    push(3'd3, 2'd3, 2'd2, 1'b0, 8'h00);
    send(8'h3E);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      check("bp_dec_valid", 32'(bus.dec_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_op_sel", 32'(bus.op_sel), 32'd3);
      check("bp_rd", 32'(bus.reg_sel_d), 32'd3);
      check("bp_rs", 32'(bus.reg_sel_s), 32'd2);
      check("bp_count", 32'(bus.instr_count), 32'(exp_count));
      tick();
    end
    bus.in_valid = 1'b0;
    issue();

    // HALT: sticky until reset, further input ignored, count frozen.
    send(8'hF0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h2D;
      check("halt_halted", 32'(bus.halted), 32'd1);
      check("halt_in_ready", 32'(bus.in_ready), 32'd0);
      check("halt_dec_valid", 32'(bus.dec_valid), 32'd0);
      check("halt_count", 32'(bus.instr_count), 32'(exp_count));
      tick();
    end
    bus.in_valid = 1'b0;
    do_reset();
    check_idle("halt_reset");

    // Reset while waiting for an immediate discards the pending instruction.
    send(8'hC8);
    check("midimm_in_ready", 32'(bus.in_ready), 32'd1);
    check("midimm_dec_valid", 32'(bus.dec_valid), 32'd0);
    do_reset();
    check_idle("midimm_reset");
    push(3'd0, 2'd0, 2'd0, 1'b0, 8'h00);
    send(8'h00);
    issue();

    // Reset while issuing: no dec_valid afterwards, count cleared.
    send(8'h15);
    check("midissue_dec_valid", 32'(bus.dec_valid), 32'd1);
    do_reset();
    check_idle("midissue_reset");

    // Opcode sweep: rd = 1, rs = 2 in every word.
    for (int op = 0; op < 16; op++) begin
      w = {op[3:0], 4'b0110};
      if (op == 15) begin
        send(w);
        check("sweep_halted", 32'(bus.halted), 32'd1);
        check("sweep_halt_in_ready", 32'(bus.in_ready), 32'd0);
      end else if (op[3]) begin
        push(op[2:0], 2'd1, 2'd2, 1'b1, 8'h5A);
        send(w);
        send(8'h5A);
        issue();
      end else begin
        push(op[2:0], 2'd1, 2'd2, 1'b0, 8'h00);
        send(w);
        issue();
      end
    end
    check("sweep_final_count", 32'(bus.instr_count), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Parametrised multi-cycle instruction decoder/sequencer for the 8-bit CPU, successor to the combinational opcode decoder. Accepts instruction words over a valid/ready stream, splits them into opcode-select and register-select fields, and fetches a second immediate word for immediate-class opcodes. It presents one decoded instruction at a time to the execute stage over a second valid/ready handshake, and latches a HALT opcode. It sits between instruction memory fetch and the ALU/register-file control.

## Interface
- DATA_W, 8, instruction/immediate word width
- OP_W, 4, opcode field width; opcode = in_data[DATA_W-1 -: OP_W]
- RS_W, 2, register-select field width; rd = in_data[2*RS_W-1 -: RS_W], rs = in_data[RS_W-1:0]; requires OP_W + 2*RS_W <= DATA_W
- CNT_W, 16, issued-instruction counter width

- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  instruction/immediate word valid
- in_data  in  DATA_W  instruction or immediate word
- in_ready  out  1  sequencer accepts a word this cycle
- dec_valid  out  1  decoded instruction valid
- dec_ready  in  1  execute stage accepts the decoded instruction
- op_sel  out  OP_W-1  operation select = opcode[OP_W-2:0]
- reg_sel_d  out  RS_W  destination register select (rd)
- reg_sel_s  out  RS_W  source register select (rs)
- imm_en  out  1  instruction carries an immediate
- imm  out  DATA_W  immediate word, 0 when imm_en = 0
- halted  out  1  HALT opcode accepted
- instr_count  out  CNT_W  number of completed issue handshakes

## Operation
- Opcode classes: all-ones = HALT; MSB = 1 (not all-ones) = immediate class; MSB = 0 = register class (opcode 0 = NOP, issued like any register op).
- States: FETCH, IMM, ISSUE, HALT. Reset state FETCH.
- FETCH: in_ready = 1. On in_valid & in_ready: latch op_sel, rd, rs. HALT -> HALT; immediate class -> IMM; register class -> ISSUE with imm_en = 0, imm = 0.
- IMM: in_ready = 1. On in_valid: latch imm = in_data, imm_en = 1 -> ISSUE. in_data's field split is ignored for this word.
- ISSUE: in_ready = 0, dec_valid = 1. op_sel, reg_sel_d, reg_sel_s, imm_en, imm held stable while dec_valid & !dec_ready. On dec_ready: instr_count += 1 (wraps at 2^CNT_W), next state FETCH.
- HALT: in_ready = 0, dec_valid = 0, halted = 1. Left only by reset. HALT itself is not issued and not counted.
- in_ready and dec_valid are decoded from state only (no combinational path from in_valid or dec_ready).

## Timing
- Reset (rst_n low at an edge): state FETCH; dec_valid, op_sel, reg_sel_d, reg_sel_s, imm_en, imm, halted, instr_count all 0. From the first cycle after that edge, in_ready = 1.
- Register op accepted at edge N: dec_valid = 1 from cycle N+1.
- Immediate op: opcode at edge N, immediate at edge M >= N+1; dec_valid = 1 from cycle M+1.
- Issue handshake at edge K: dec_valid = 0 and in_ready = 1 in cycle K+1. Peak throughput: one register op per 2 cycles, one immediate op per 3 cycles.
- in_valid low in FETCH/IMM: wait indefinitely, latched fields unchanged.
- Reset mid-operation (IMM or ISSUE): pending instruction discarded, no dec_valid, instr_count cleared.
- in_data ignored whenever in_ready = 0.

## Test plan
- Reset then register op: in_data = 8'h2D (op 2, rd 3, rs 1), dec_ready = 1 -> dec_valid one cycle later with op_sel = 2, reg_sel_d = 3, reg_sel_s = 1, imm_en = 0, imm = 0; instr_count = 1.
- Immediate op: 8'h94 then 8'hA5 with a 3-cycle in_valid gap -> in_ready high throughout the gap; dec_valid with op_sel = 1, reg_sel_d = 1, reg_sel_s = 0, imm_en = 1, imm = 8'hA5.
- Backpressure: dec_ready low 5 cycles during ISSUE -> outputs stable, in_ready = 0, instr_count unchanged until dec_ready rises; then +1.
- HALT: in_data = 8'hF0 -> halted = 1, in_ready = 0 permanently, further in_valid ignored, instr_count unchanged; rst_n low one edge -> halted = 0, in_ready = 1.
- Reset mid-IMM: accept 8'hC8, assert rst_n low before immediate -> no dec_valid, all outputs 0; next 8'h00 issues NOP with op_sel = 0.
- Sweep all 16 opcodes (register-class ones with dec_ready = 1, immediate-class ones followed by 8'h5A) -> op_sel = opcode[2:0] for 0-14, imm_en = opcode[3] for 0-14, HALT on 15; instr_count = 15 at end.
